// File: rtl/mmio_map_pkg.sv
// Shared constants and types for the load/store router: register offsets,
// the ID word and the response target tag.
package mmio_map_pkg;

  localparam logic [15:0] OFF_ID      = 16'h0000;
  localparam logic [15:0] OFF_LED     = 16'h0008;
  localparam logic [15:0] OFF_CYCLE   = 16'h000C;
  localparam logic [15:0] OFF_SCRATCH = 16'h0010;

  localparam logic [31:0] ID_VALUE = 32'h4D455448;

  typedef enum logic {
    TGT_MEM  = 1'b0,
    TGT_MMIO = 1'b1
  } tgt_e;

endpackage

// File: rtl/mmio_regs.sv
// MMIO register bank: ID, LED, free-running CYCLE and SCRATCH, with per-lane
// byte-enable writes and a combinational read mux of the pre-edge values.
module mmio_regs
  import mmio_map_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int LED_W          = 8,
  parameter int MMIO_SPAN_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [MMIO_SPAN_LOG2-1:0] off,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       we,
  output logic [DATA_W-1:0]         rdata,
  output logic [LED_W-1:0]          led
);

  localparam int LANES = DATA_W / 8;

  localparam logic [MMIO_SPAN_LOG2-1:0] A_ID      = MMIO_SPAN_LOG2'(OFF_ID);
  localparam logic [MMIO_SPAN_LOG2-1:0] A_LED     = MMIO_SPAN_LOG2'(OFF_LED);
  localparam logic [MMIO_SPAN_LOG2-1:0] A_CYCLE   = MMIO_SPAN_LOG2'(OFF_CYCLE);
  localparam logic [MMIO_SPAN_LOG2-1:0] A_SCRATCH = MMIO_SPAN_LOG2'(OFF_SCRATCH);

  logic [LED_W-1:0]  led_q;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] cycle_q;
  logic [DATA_W-1:0] led_wide;
  logic [DATA_W-1:0] scratch_nxt;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [LANES-1:0]  lane_en
  );
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    led_wide    = merge_lanes(DATA_W'(led_q), wdata, we);
    scratch_nxt = merge_lanes(scratch_q, wdata, we);
  end

  // Writes land at the accepting edge; CYCLE counts every cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      led_q     <= '0;
      scratch_q <= '0;
      cycle_q   <= '0;
    end else begin
      cycle_q <= cycle_q + DATA_W'(1);
      if (wr_en && off == A_LED)     led_q     <= led_wide[LED_W-1:0];
      if (wr_en && off == A_SCRATCH) scratch_q <= scratch_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      A_ID:      rdata = DATA_W'(ID_VALUE);
      A_LED:     rdata = DATA_W'(led_q);
      A_CYCLE:   rdata = cycle_q;
      A_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: rtl/mmio_map.sv
// Core load/store router: steers each access to data memory or the MMIO
// register bank and returns all read data through one fixed-latency pipeline.
module mmio_map
  import mmio_map_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                MEM_LATENCY    = 1,
  parameter int                LED_W          = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE      = 'h10000,
  parameter int                MMIO_SPAN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                c_req,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_din,
  input  logic [DATA_W/8-1:0] c_we,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_dout,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_din,
  output logic [DATA_W/8-1:0] m_we,
  input  logic [DATA_W-1:0]   m_dout,
  output logic [LED_W-1:0]    led
);

  logic              hit;
  logic              rd_acc;
  logic              mmio_wr;
  logic [DATA_W-1:0] mmio_rdata;

  logic              vld_p [MEM_LATENCY];
  tgt_e              tgt_p [MEM_LATENCY];
  logic [DATA_W-1:0] dat_p [MEM_LATENCY];

  assign hit     = (c_addr >> MMIO_SPAN_LOG2) == (MMIO_BASE >> MMIO_SPAN_LOG2);
  assign rd_acc  = c_req & ~(|c_we);
  assign mmio_wr = c_req & hit & (|c_we);

  // Memory pass-through; requests are suppressed while reset is held.
  assign m_req  = c_req & ~hit & rstn;
  assign m_addr = c_addr;
  assign m_din  = c_din;
  assign m_we   = hit ? '0 : c_we;

  mmio_regs #(
    .DATA_W         (DATA_W),
    .LED_W          (LED_W),
    .MMIO_SPAN_LOG2 (MMIO_SPAN_LOG2)
  ) u_regs (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (mmio_wr),
    .off   (c_addr[MMIO_SPAN_LOG2-1:0]),
    .wdata (c_din),
    .we    (c_we),
    .rdata (mmio_rdata),
    .led   (led)
  );

  // Response pipeline, stage 0 captured at the accepting edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < MEM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tgt_p[0] <= hit ? TGT_MMIO : TGT_MEM;
    dat_p[0] <= mmio_rdata;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tgt_p[i] <= tgt_p[i-1];
      dat_p[i] <= dat_p[i-1];
    end
  end

  // Output stage: memory data is aligned with the last pipeline stage.
  assign c_rvalid = vld_p[MEM_LATENCY-1] & rstn;

  always_comb begin
    c_dout = '0;
    if (c_rvalid) begin
      c_dout = (tgt_p[MEM_LATENCY-1] == TGT_MMIO) ? dat_p[MEM_LATENCY-1] : m_dout;
    end
  end

endmodule

// File: tb/tb_mmio_map.sv
// Directed bench for mmio_map with MEM_LATENCY=2 and a small latency-matched
// memory model returning fixed values per address.
module tb_mmio_map;

  logic        clk = 1'b0;
  logic        rstn;
  logic        c_req;
  logic [31:0] c_addr;
  logic [31:0] c_din;
  logic [3:0]  c_we;
  logic        c_rvalid;
  logic [31:0] c_dout;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [3:0]  m_we;
  logic [31:0] m_dout;
  logic [7:0]  led;

  int errors = 0;
  int checks = 0;

  mmio_map #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .MEM_LATENCY    (2),
    .LED_W          (8),
    .MMIO_BASE      (32'h10000),
    .MMIO_SPAN_LOG2 (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .c_req    (c_req),
    .c_addr   (c_addr),
    .c_din    (c_din),
    .c_we     (c_we),
    .c_rvalid (c_rvalid),
    .c_dout   (c_dout),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_we     (m_we),
    .m_dout   (m_dout),
    .led      (led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      default: return a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Memory with two-cycle read latency; drives a poison value when idle.
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [31:0] ra0 = '0, ra1 = '0;
  always @(posedge clk) begin
    rv0 <= m_req && (m_we == 4'b0000);
    ra0 <= m_addr;
    rv1 <= rv0;
    ra1 <= ra0;
  end
  assign m_dout = rv1 ? mem_val(ra1) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    c_req = 1'b1; c_addr = a; c_din = '0; c_we = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    c_req = 1'b1; c_addr = a; c_din = d; c_we = w;
  endtask

  task automatic idle();
    c_req = 1'b0; c_addr = '0; c_din = '0; c_we = 4'b0000;
  endtask

  logic [31:0] d1, d2;

  initial begin
    rstn = 1'b0;
    rd(32'h100);
    repeat (3) tick();
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_led", {24'b0, led}, 32'd0);
    chk("rst_rvalid", {31'b0, c_rvalid}, 32'd0);
    chk("rst_dout", c_dout, 32'd0);

    // CYCLE read right out of reset
    rstn = 1'b1;
    rd(32'h1000C);
    tick(); idle();
    chk("cyc_lat_early", {31'b0, c_rvalid}, 32'd0);
    tick();
    chk("cyc_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("cyc_small", {31'b0, (c_dout <= 32'd2)}, 32'd1);

    // ID read, two-cycle latency, no memory request
    rd(32'h10000);
    #1 chk("id_m_req", {31'b0, m_req}, 32'd0);
    tick(); idle();
    chk("id_lat_early", {31'b0, c_rvalid}, 32'd0);
    tick();
    chk("id_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("id_data", c_dout, 32'h4D455448);

    // LED byte write, then read back next cycle
    wr(32'h10008, 32'hA5A5A5A5, 4'b0001);
    #1 chk("led_wr_m_we", {28'b0, m_we}, 32'd0);
    tick();
    chk("led_val", {24'b0, led}, 32'hA5);
    rd(32'h10008);
    tick(); idle();
    chk("wr_no_rvalid", {31'b0, c_rvalid}, 32'd0);
    tick();
    chk("led_rd", c_dout, 32'h000000A5);
    wr(32'h10008, 32'h0000FF00, 4'b0010);
    tick();
    chk("led_upper_lane", {24'b0, led}, 32'hA5);

    // SCRATCH lane merge, then mixed mem/MMIO read ordering
    wr(32'h10010, 32'h1234DEAD, 4'b1111);
    tick();
    wr(32'h10010, 32'h00000000, 4'b1100);
    tick();
    rd(32'h100);
    tick();
    rd(32'h10010);
    tick();
    chk("mix0_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("mix0_data", c_dout, 32'h11);
    rd(32'h104);
    tick();
    chk("mix1_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("mix1_data", c_dout, 32'h0000DEAD);
    idle();
    tick();
    chk("mix2_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("mix2_data", c_dout, 32'h22);
    tick();
    chk("idle_rvalid", {31'b0, c_rvalid}, 32'd0);
    chk("idle_dout", c_dout, 32'd0);

    // ID is read-only
    wr(32'h10000, 32'hFFFFFFFF, 4'b1111);
    tick();
    rd(32'h10000);
    tick(); idle();
    tick();
    chk("id_ro", c_dout, 32'h4D455448);

    // Unmapped offset inside the window
    rd(32'h10040);
    #1 chk("unmap_m_req", {31'b0, m_req}, 32'd0);
    tick(); idle();
    tick();
    chk("unmap_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("unmap_data", c_dout, 32'd0);

    // First address past the window goes to memory
    rd(32'h10100);
    #1 chk("edge_m_req", {31'b0, m_req}, 32'd1);
    tick(); idle();
    tick();
    chk("edge_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("edge_data", c_dout, 32'h5A5B0100);

    // Memory write pass-through
    wr(32'h200, 32'hCAFEF00D, 4'b0011);
    #1;
    chk("mw_m_req", {31'b0, m_req}, 32'd1);
    chk("mw_m_we", {28'b0, m_we}, 32'h3);
    chk("mw_m_din", m_din, 32'hCAFEF00D);
    tick(); idle();

    // Back-to-back CYCLE reads differ by one
    rd(32'h1000C);
    tick();
    rd(32'h1000C);
    tick(); idle();
    d1 = c_dout;
    chk("cyc0_rvalid", {31'b0, c_rvalid}, 32'd1);
    tick();
    d2 = c_dout;
    chk("cyc1_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("cyc_step", d2 - d1, 32'd1);
    tick();

    // Reset while a memory read is in flight
    rd(32'h100);
    tick();
    rstn = 1'b0; idle();
    tick();
    chk("mid_rst_rvalid0", {31'b0, c_rvalid}, 32'd0);
    rstn = 1'b1;
    tick();
    chk("mid_rst_rvalid1", {31'b0, c_rvalid}, 32'd0);
    chk("mid_rst_led", {24'b0, led}, 32'd0);
    rd(32'h10010);
    tick(); idle();
    chk("mid_rst_rvalid2", {31'b0, c_rvalid}, 32'd0);
    tick();
    chk("scratch_rst", c_dout, 32'd0);
    chk("scratch_rst_v", {31'b0, c_rvalid}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
